// File: rtl/wino_pad_bridge.sv
// Pad-side bridge for the Winograd cores: deserialises narrow pad beats into core
// words through a FWFT FIFO, and serialises core result words back onto the pads.
module wino_pad_bridge #(
  parameter int unsigned PAD_W      = 10,
  parameter int unsigned IN_BEATS   = 2,
  parameter int unsigned OUT_BEATS  = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PAD_W-1:0]             pad_d,
  input  logic                         pad_vld,
  input  logic                         pad_sof,
  output logic [PAD_W*IN_BEATS-1:0]    core_in_data,
  output logic                         core_in_valid,
  input  logic                         core_in_ready,
  input  logic [PAD_W*OUT_BEATS-1:0]   core_out_data,
  input  logic                         core_out_valid,
  output logic                         core_out_ready,
  output logic [PAD_W-1:0]             pad_z,
  output logic                         pad_z_vld,
  input  logic                         clr,
  output logic                         ovf,
  output logic                         sync_err
);

  localparam int unsigned IN_W  = PAD_W * IN_BEATS;
  localparam int unsigned OUT_W = PAD_W * OUT_BEATS;
  localparam int unsigned KW    = (IN_BEATS > 1) ? $clog2(IN_BEATS) : 1;
  localparam int unsigned OBW   = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CW    = AW + 1;

  // Deserializer: a sof beat always restarts assembly at beat 0
  logic [KW-1:0]   k_q, k_d, eff_k;
  logic [IN_W-1:0] asm_q, asm_d;
  logic            push_c, desync_c;

  always_comb begin
    k_d      = k_q;
    asm_d    = asm_q;
    eff_k    = k_q;
    push_c   = 1'b0;
    desync_c = 1'b0;
    if (pad_vld) begin
      if (pad_sof) begin
        eff_k    = '0;
        desync_c = (k_q != '0);
      end
      asm_d[eff_k*PAD_W +: PAD_W] = pad_d;
      if (eff_k == KW'(IN_BEATS - 1)) begin
        push_c = 1'b1;
        k_d    = '0;
      end else begin
        k_d = eff_k + KW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k_q   <= '0;
      asm_q <= '0;
    end else begin
      k_q   <= k_d;
      asm_q <= asm_d;
    end
  end

  // Input FIFO; a full FIFO still accepts a push when it pops in the same cycle
  logic [IN_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [CW-1:0]   cnt;
  logic            pop_c, push_ok_c;

  assign core_in_valid = (cnt != '0);
  assign core_in_data  = mem[rptr];
  assign pop_c         = core_in_valid & core_in_ready;
  assign push_ok_c     = push_c & ((cnt < CW'(FIFO_DEPTH)) | pop_c);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push_ok_c) begin
        mem[wptr] <= asm_d;
        wptr      <= wptr + AW'(1);
      end
      if (pop_c) rptr <= rptr + AW'(1);
      cnt <= cnt + CW'(push_ok_c) - CW'(pop_c);
    end
  end

  // Sticky flags; a new event wins over a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf      <= 1'b0;
      sync_err <= 1'b0;
    end else begin
      ovf      <= (push_c & ~push_ok_c) | (ovf & ~clr);
      sync_err <= desync_c | (sync_err & ~clr);
    end
  end

  // Serializer FSM; beat_q is the index of the beat currently on pad_z
  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           state_q, state_d;
  logic [OBW-1:0]   beat_q, beat_d;
  logic [OUT_W-1:0] sh_q, sh_d;
  logic [PAD_W-1:0] pad_z_d;
  logic             pad_z_vld_d;
  logic             last_c, accept_c;

  assign last_c         = (state_q == S_SHIFT) & (beat_q == OBW'(OUT_BEATS - 1));
  assign core_out_ready = ~rst & ((state_q == S_IDLE) | last_c);
  assign accept_c       = core_out_valid & core_out_ready;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    sh_d        = sh_q;
    pad_z_d     = pad_z;
    pad_z_vld_d = pad_z_vld;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          state_d     = S_SHIFT;
          beat_d      = '0;
          pad_z_d     = core_out_data[PAD_W-1:0];
          sh_d        = core_out_data >> PAD_W;
          pad_z_vld_d = 1'b1;
        end
      end
      S_SHIFT: begin
        if (last_c) begin
          if (accept_c) begin
            beat_d      = '0;
            pad_z_d     = core_out_data[PAD_W-1:0];
            sh_d        = core_out_data >> PAD_W;
            pad_z_vld_d = 1'b1;
          end else begin
            state_d     = S_IDLE;
            pad_z_vld_d = 1'b0;
          end
        end else begin
          beat_d      = beat_q + OBW'(1);
          pad_z_d     = sh_q[PAD_W-1:0];
          sh_d        = sh_q >> PAD_W;
          pad_z_vld_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      beat_q    <= '0;
      sh_q      <= '0;
      pad_z     <= '0;
      pad_z_vld <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      sh_q      <= sh_d;
      pad_z     <= pad_z_d;
      pad_z_vld <= pad_z_vld_d;
    end
  end

endmodule

// File: tb/tb_wino_pad_bridge.sv
// Scoreboard bench for wino_pad_bridge: expected core words and pad beats are queued
// as stimulus is driven and compared when the DUT hands them over.
module tb_wino_pad_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  pad_d;
  logic        pad_vld;
  logic        pad_sof;
  logic [19:0] core_in_data;
  logic        core_in_valid;
  logic        core_in_ready;
  logic [19:0] core_out_data;
  logic        core_out_valid;
  logic        core_out_ready;
  logic [9:0]  pad_z;
  logic        pad_z_vld;
  logic        clr;
  logic        ovf;
  logic        sync_err;

  wino_pad_bridge #(
    .PAD_W(10), .IN_BEATS(2), .OUT_BEATS(2), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .pad_d(pad_d), .pad_vld(pad_vld), .pad_sof(pad_sof),
    .core_in_data(core_in_data), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .pad_z(pad_z), .pad_z_vld(pad_z_vld),
    .clr(clr), .ovf(ovf), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [19:0] in_q[$];
  logic [9:0]  out_q[$];
  int          run_len = 0;
  int          last_run = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: compare every handshake and every pad beat against the queues
  always @(negedge clk) begin
    if (!rst) begin
      if (core_in_valid && core_in_ready) begin
        if (in_q.size() == 0) check("in_unexp", 32'(in_q.size()), 1);
        else check("in_data", 32'(core_in_data), 32'(in_q.pop_front()));
      end
      if (pad_z_vld) begin
        run_len++;
        if (out_q.size() == 0) check("out_unexp", 32'(out_q.size()), 1);
        else check("pad_z", 32'(pad_z), 32'(out_q.pop_front()));
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [9:0] d, input logic sof);
    pad_d   = d;
    pad_vld = 1'b1;
    pad_sof = sof;
    tick();
    pad_vld = 1'b0;
    pad_sof = 1'b0;
  endtask

  task automatic send_word(input logic [19:0] w);
    send_beat(w[9:0], 1'b1);
    send_beat(w[19:10], 1'b0);
  endtask

  task automatic send_out(input logic [19:0] w);
    int n = 0;
    core_out_data  = w;
    core_out_valid = 1'b1;
    out_q.push_back(w[9:0]);
    out_q.push_back(w[19:10]);
    while (!core_out_ready && n < 20) begin
      tick();
      n++;
    end
    check("out_rdy", 32'(core_out_ready), 1);
    tick();
  endtask

  task automatic wait_in_drain();
    int n = 0;
    while (in_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("in_drain", 32'(in_q.size()), 0);
  endtask

  task automatic wait_out_drain();
    int n = 0;
    while (out_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    check("out_drain", 32'(out_q.size()), 0);
  endtask

  function automatic logic [19:0] mkw(input int i);
    return 20'((i << 10) | (i * 37 + 3));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; clr = 1'b0;
    pad_d = '0; pad_vld = 1'b0; pad_sof = 1'b0;
    core_in_ready = 1'b0; core_out_data = '0; core_out_valid = 1'b0;
    tick();
    tick();
    check("rst_pad_z",    32'(pad_z), 0);
    check("rst_z_vld",    32'(pad_z_vld), 0);
    check("rst_in_valid", 32'(core_in_valid), 0);
    check("rst_in_data",  32'(core_in_data), 0);
    check("rst_ovf",      32'(ovf), 0);
    check("rst_sync_err", 32'(sync_err), 0);
    check("rst_out_rdy",  32'(core_out_ready), 0);
    rst = 1'b0;
    #1;
    check("rel_out_rdy", 32'(core_out_ready), 1);
    tick();

    // Basic assembly: LSB-first, visible the cycle after the last beat
    send_beat(10'h155, 1'b1);
    check("valid_early", 32'(core_in_valid), 0);
    send_beat(10'h0AA, 1'b0);
    check("valid_next", 32'(core_in_valid), 1);
    check("data_first", 32'(core_in_data), 32'h2A955);
    in_q.push_back(20'h2A955);
    core_in_ready = 1'b1;
    wait_in_drain();
    check("valid_empty", 32'(core_in_valid), 0);

    // Overflow: depth 4, fifth word dropped
    core_in_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      send_word(mkw(i));
      if (i <= 4) in_q.push_back(mkw(i));
      if (i == 4) check("ovf_full_ok", 32'(ovf), 0);
    end
    check("ovf_set", 32'(ovf), 1);
    core_in_ready = 1'b1;
    wait_in_drain();
    check("valid_after_drain", 32'(core_in_valid), 0);
    core_in_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("ovf_clr", 32'(ovf), 0);

    // Resync: partial word discarded by a sof beat
    in_q.push_back(20'h003FF);
    core_in_ready = 1'b1;
    send_beat(10'h001, 1'b1);
    check("serr_pre", 32'(sync_err), 0);
    send_beat(10'h3FF, 1'b1);
    check("serr_set", 32'(sync_err), 1);
    send_beat(10'h000, 1'b0);
    wait_in_drain();
    tick();
    check("valid_single", 32'(core_in_valid), 0);

    // Set beats a simultaneous clear
    in_q.push_back(20'h2ECAA);
    send_beat(10'h055, 1'b1);
    clr = 1'b1;
    send_beat(10'h0AA, 1'b1);
    clr = 1'b0;
    check("serr_prio", 32'(sync_err), 1);
    send_beat(10'h0BB, 1'b0);
    wait_in_drain();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("serr_clr", 32'(sync_err), 0);

    // Serializer: back-to-back words with no bubble
    send_out(20'hFFC01);
    send_out(20'h00155);
    core_out_valid = 1'b0;
    wait_out_drain();
    tick();
    tick();
    check("run_len", 32'(last_run), 4);
    check("z_vld_low", 32'(pad_z_vld), 0);
    send_out(20'h2A9C7);
    core_out_valid = 1'b0;
    wait_out_drain();
    tick();
    tick();
    check("z_hold", 32'(pad_z), 32'h0AA);
    check("run_len_single", 32'(last_run), 2);

    // Reset during beat 1 with a queued word and a partial word in flight
    core_in_ready = 1'b0;
    send_word(20'h12345);
    send_beat(10'h111, 1'b1);
    send_out(20'h54321);
    core_out_valid = 1'b0;
    tick();
    check("z_vld_pre", 32'(pad_z_vld), 1);
    #2;
    rst = 1'b1;
    #1;
    out_q.delete();
    check("mid_z_vld",    32'(pad_z_vld), 0);
    check("mid_pad_z",    32'(pad_z), 0);
    check("mid_in_valid", 32'(core_in_valid), 0);
    check("mid_out_rdy",  32'(core_out_ready), 0);
    tick();
    rst = 1'b0;
    #1;
    check("post_out_rdy",  32'(core_out_ready), 1);
    check("post_in_valid", 32'(core_in_valid), 0);
    tick();
    in_q.push_back(20'hCCE22);
    send_beat(10'h222, 1'b0);
    send_beat(10'h333, 1'b0);
    core_in_ready = 1'b1;
    wait_in_drain();
    repeat (3) tick();
    check("post_z_vld", 32'(pad_z_vld), 0);
    check("post_in_empty", 32'(core_in_valid), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
